// File: rtl/rr_grant_scheduler8_if.sv
// Requester-side bundle for the 8-way round-robin scheduler.
// Pure wiring, no latency.
// No backpressure: requests are level-held until granted.
interface rr_grant_scheduler8_if;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic [2:0] ptr;

  // Requesters drive en/req and observe the grant.
  modport master (
    output en, req,
    input  gnt, gnt_idx, gnt_valid, ptr
  );

  // The scheduler consumes en/req and drives the grant.
  modport slave (
    input  en, req,
    output gnt, gnt_idx, gnt_valid, ptr
  );
endinterface

// File: rtl/rr_grant_scheduler8.sv
// Round-robin scheduler sharing one resource among 8 requesters, with a hold-time limit.
// Latency: a request sampled at an edge is granted on that edge (visible one cycle later).
// Backpressure: a requester simply keeps req high until it sees its gnt bit.
module rr_grant_scheduler8 #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  rr_grant_scheduler8_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  // Last hold count before a forced release; only meaningful when limited.
  localparam bit         HOLD_LIMITED = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST    = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] gnt_idx_q, gnt_idx_d;
  logic       gnt_valid_q, gnt_valid_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;

  logic [2:0] scan_start;
  logic       win_found;
  logic [2:0] win_idx;
  logic       release_now;

  // First set bit scanning circularly from start; {found, index}.
  // Walking offsets high-to-low lets the lowest offset overwrite the result.
  function automatic logic [3:0] pick(input logic [7:0] r, input logic [2:0] start);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      idx = start + 3'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Next-state: arbitration from ptr when idle, from g+1 on release so g is scanned last.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;

    scan_start  = (state_q == GRANT) ? (gnt_idx_q + 3'd1) : ptr_q;
    {win_found, win_idx} = pick(bus.req, scan_start);

    release_now = !bus.req[gnt_idx_q] ||
                  (HOLD_LIMITED && (hold_cnt_q == HOLD_LAST));

    case (state_q)
      IDLE: begin
        if (bus.en && win_found) begin
          state_d     = GRANT;
          gnt_idx_d   = win_idx;
          gnt_valid_d = 1'b1;
          gnt_d       = 8'd1 << win_idx;
          hold_cnt_d  = 8'd0;
        end
      end
      GRANT: begin
        if (!release_now) begin
          if (hold_cnt_q != 8'hFF) hold_cnt_d = hold_cnt_q + 8'd1;
        end else begin
          ptr_d = gnt_idx_q + 3'd1;
          if (bus.en && win_found) begin
            gnt_idx_d   = win_idx;
            gnt_d       = 8'd1 << win_idx;
            hold_cnt_d  = 8'd0;
          end else begin
            state_d     = IDLE;
            gnt_valid_d = 1'b0;
            gnt_d       = 8'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset that overrides an active grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= 8'd0;
      gnt_idx_q   <= 3'd0;
      gnt_valid_q <= 1'b0;
      ptr_q       <= 3'd0;
      hold_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.ptr       = ptr_q;

endmodule

// File: tb/tb_rr_grant_scheduler8.sv
// Directed bench for rr_grant_scheduler8: a hold-limited instance and an unlimited one.
// Inputs change 1ns after each rising edge; outputs are checked at the same point.
// Expected values are hand-derived from the round-robin rules.
module tb_rr_grant_scheduler8;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  rr_grant_scheduler8_if if_a ();
  rr_grant_scheduler8_if if_b ();

  rr_grant_scheduler8 #(.MAX_HOLD(4)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  rr_grant_scheduler8 #(.MAX_HOLD(0)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    if_a.en = 1'b0; if_a.req = 8'h00;
    if_b.en = 1'b0; if_b.req = 8'h00;
    tick(); tick();

    // Reset state
    chk("rst_gnt",   if_a.gnt, 8'h00);
    chk("rst_valid", {7'd0, if_a.gnt_valid}, 8'h00);
    chk("rst_idx",   {5'd0, if_a.gnt_idx}, 8'h00);
    chk("rst_ptr",   {5'd0, if_a.ptr}, 8'h00);
    rst = 1'b0;

    // Unlimited hold: req[5] alone for 300 cycles never releases
    if_b.en = 1'b1; if_b.req = 8'h20;
    for (int c = 0; c < 300; c++) begin
      tick();
      chk("unlim_gnt", if_b.gnt, 8'h20);
    end
    chk("unlim_hold_sat", dut_b.hold_cnt_q, 8'hFF);
    chk("unlim_ptr", {5'd0, if_b.ptr}, 8'h00);
    if_b.req = 8'h00;
    tick();
    chk("unlim_rel_gnt", if_b.gnt, 8'h00);
    chk("unlim_rel_ptr", {5'd0, if_b.ptr}, 8'h06);

    // All requesting from ptr=0: each index holds exactly 4 cycles, wrapping 7->0
    if_a.en = 1'b1; if_a.req = 8'hFF;
    for (int n = 0; n < 9; n++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        chk("walk_gnt", if_a.gnt, 8'd1 << (n % 8));
        chk("walk_ptr", {5'd0, if_a.ptr}, 8'(n % 8));
        chk("walk_valid", {7'd0, if_a.gnt_valid}, 8'h01);
      end
    end
    if_a.req = 8'h00;
    tick();
    chk("walk_end_gnt", if_a.gnt, 8'h00);
    chk("walk_end_ptr", {5'd0, if_a.ptr}, 8'h01);

    // Single request on 2, then drop
    if_a.req = 8'h04;
    tick();
    chk("s1_gnt", if_a.gnt, 8'h04);
    chk("s1_idx", {5'd0, if_a.gnt_idx}, 8'h02);
    chk("s1_valid", {7'd0, if_a.gnt_valid}, 8'h01);
    chk("s1_ptr_hold", {5'd0, if_a.ptr}, 8'h01);
    if_a.req = 8'h00;
    tick();
    chk("s1_rel_gnt", if_a.gnt, 8'h00);
    chk("s1_rel_valid", {7'd0, if_a.gnt_valid}, 8'h00);
    chk("s1_rel_ptr", {5'd0, if_a.ptr}, 8'h03);
    chk("s1_rel_idx", {5'd0, if_a.gnt_idx}, 8'h02);

    // ptr=3, req 0 and 2: index 0 wins via wrap, then index 2 after timeout
    if_a.req = 8'h05;
    tick();
    chk("wrap_gnt", if_a.gnt, 8'h01);
    tick(); tick(); tick();
    chk("wrap_hold4", if_a.gnt, 8'h01);
    tick();
    chk("wrap_next_gnt", if_a.gnt, 8'h04);
    chk("wrap_next_ptr", {5'd0, if_a.ptr}, 8'h01);
    if_a.req = 8'h00;
    tick();
    chk("wrap_end_ptr", {5'd0, if_a.ptr}, 8'h03);

    // Grant on 6, en drops, req[1] appears: grant kept, then released without re-grant
    if_a.req = 8'h40;
    tick();
    chk("en_gnt6", if_a.gnt, 8'h40);
    if_a.en = 1'b0; if_a.req = 8'h42;
    tick();
    chk("en_low_keep", if_a.gnt, 8'h40);
    if_a.req = 8'h02;
    tick();
    chk("en_low_rel_gnt", if_a.gnt, 8'h00);
    chk("en_low_rel_valid", {7'd0, if_a.gnt_valid}, 8'h00);
    chk("en_low_rel_ptr", {5'd0, if_a.ptr}, 8'h07);
    chk("en_low_rel_idx", {5'd0, if_a.gnt_idx}, 8'h06);
    if_a.en = 1'b1;
    tick();
    chk("en_high_gnt", if_a.gnt, 8'h02);
    chk("en_high_ptr", {5'd0, if_a.ptr}, 8'h07);

    // Back-to-back handoff 1 -> 4, then reset mid-grant
    if_a.req = 8'h10;
    tick();
    chk("b2b_gnt", if_a.gnt, 8'h10);
    chk("b2b_ptr", {5'd0, if_a.ptr}, 8'h02);
    rst = 1'b1; if_a.req = 8'hFF;
    tick();
    chk("mid_rst_gnt", if_a.gnt, 8'h00);
    chk("mid_rst_valid", {7'd0, if_a.gnt_valid}, 8'h00);
    chk("mid_rst_ptr", {5'd0, if_a.ptr}, 8'h00);
    chk("mid_rst_idx", {5'd0, if_a.gnt_idx}, 8'h00);
    rst = 1'b0;
    tick();
    chk("post_rst_gnt", if_a.gnt, 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
